// File: rtl/rally_speed_ctrl_if.sv
// Bundle between the collision logic / divider and the rally sequencer.
// Master drives game events and the divider clock; slave returns speed and game status.
interface rally_speed_ctrl_if;
    logic       div_clk;
    logic       serve_btn;
    logic       paddle_hit;
    logic       miss_l;
    logic       miss_r;
    logic [2:0] speed_level;
    logic       run;
    logic       point_flag;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;

    modport master (
        output div_clk, serve_btn, paddle_hit, miss_l, miss_r,
        input  speed_level, run, point_flag, score_l, score_r, game_over, winner
    );

    modport slave (
        input  div_clk, serve_btn, paddle_hit, miss_l, miss_r,
        output speed_level, run, point_flag, score_l, score_r, game_over, winner
    );
endinterface

// File: rtl/rally_speed_ctrl.sv
// Rally sequencer (IDLE/SERVE/RALLY/POINT/GAME_OVER): ramps ball speed on hits, scores misses; SERVE_TIMEOUT_EN adds auto-serve.
// Outputs registered one clk after the cause (div_clk/serve_btn add 2-3 clk sync); no backpressure, events outside RALLY dropped.
module rally_speed_ctrl #(
    parameter int HITS_PER_LEVEL = 3,
    parameter int MAX_LEVEL      = 7,
    parameter int HOLD_STEPS     = 4,
    parameter int WIN_SCORE      = 9,
    parameter int SERVE_TIMEOUT  = 10
) (
    input  logic              clk_in,
    input  logic              rst_n,
    rally_speed_ctrl_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_RALLY = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [3:0] HITS_M1 = 4'(HITS_PER_LEVEL - 1);
    localparam logic [2:0] MAX_L   = 3'(MAX_LEVEL);
    localparam logic [7:0] HOLD_M1 = 8'(HOLD_STEPS - 1);
    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);

    if (HITS_PER_LEVEL < 1 || HITS_PER_LEVEL > 15 || MAX_LEVEL < 0 || MAX_LEVEL > 7 ||
        HOLD_STEPS < 1 || HOLD_STEPS > 255 || WIN_SCORE < 1 || WIN_SCORE > 15 ||
        SERVE_TIMEOUT < 1 || SERVE_TIMEOUT > 255) begin : g_param_range
        $error("rally_speed_ctrl: parameter out of legal range");
    end

    logic [2:0] div_sync_q;
    logic [2:0] btn_sync_q;
    logic       step;
    logic       serve_p;
    logic       timeout;

    logic [2:0] state_q, state_d;
    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic [2:0] level_q, level_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       winner_q, winner_d;
    logic       run_q, point_q, over_q;
    logic       enter_serve;

    // Bits [1:0] form the synchronizer; bit 2 is the previous synced value for edge detect.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_sync_q <= '0;
            btn_sync_q <= '0;
        end else begin
            div_sync_q <= {div_sync_q[1:0], bus.div_clk};
            btn_sync_q <= {btn_sync_q[1:0], bus.serve_btn};
        end
    end

    assign step    = div_sync_q[1] ^ div_sync_q[2];
    assign serve_p = btn_sync_q[1] & ~btn_sync_q[2];

`ifdef SERVE_TIMEOUT_EN
    localparam logic [7:0] TO_M1 = 8'(SERVE_TIMEOUT - 1);
    logic [7:0] to_cnt_q, to_cnt_d;

    // Held at zero outside SERVE, so every SERVE entry starts a fresh count.
    assign to_cnt_d = (state_q == ST_SERVE) ? to_cnt_q + {7'd0, step} : 8'd0;
    assign timeout  = step && (to_cnt_q == TO_M1);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == WIN_S) ? s : s + 4'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        hit_cnt_d   = hit_cnt_q;
        level_d     = level_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        hold_cnt_d  = hold_cnt_q;
        winner_d    = winner_q;
        enter_serve = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (serve_p) begin
                    state_d     = ST_SERVE;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    enter_serve = 1'b1;
                end
            end
            ST_SERVE: begin
                if (serve_p || timeout) state_d = ST_RALLY;
            end
            ST_RALLY: begin
                // miss_l wins a double miss; any miss masks a same-cycle hit.
                if (bus.miss_l) begin
                    state_d    = ST_POINT;
                    score_r_d  = sat_inc(score_r_q);
                    hold_cnt_d = '0;
                end else if (bus.miss_r) begin
                    state_d    = ST_POINT;
                    score_l_d  = sat_inc(score_l_q);
                    hold_cnt_d = '0;
                end else if (bus.paddle_hit) begin
                    if (hit_cnt_q == HITS_M1) begin
                        hit_cnt_d = '0;
                        if (level_q < MAX_L) level_d = level_q + 3'd1;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 4'd1;
                    end
                end
            end
            ST_POINT: begin
                if (step) begin
                    if (hold_cnt_q == HOLD_M1) begin
                        if (score_l_q == WIN_S || score_r_q == WIN_S) begin
                            state_d  = ST_OVER;
                            winner_d = (score_r_q == WIN_S);
                        end else begin
                            state_d     = ST_SERVE;
                            enter_serve = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
            ST_OVER: begin
                if (serve_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_serve) begin
            level_d   = '0;
            hit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hit_cnt_q  <= '0;
            level_q    <= '0;
            score_l_q  <= '0;
            score_r_q  <= '0;
            hold_cnt_q <= '0;
            winner_q   <= 1'b0;
            run_q      <= 1'b0;
            point_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            level_q    <= level_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            hold_cnt_q <= hold_cnt_d;
            winner_q   <= winner_d;
            run_q      <= (state_d == ST_RALLY);
            point_q    <= (state_d == ST_POINT);
            over_q     <= (state_d == ST_OVER);
        end
    end

    assign bus.speed_level = level_q;
    assign bus.run         = run_q;
    assign bus.point_flag  = point_q;
    assign bus.score_l     = score_l_q;
    assign bus.score_r     = score_r_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_rally_speed_ctrl.sv
// Bench for rally_speed_ctrl: directed scenarios then random events, checked against a game-level model.
`timescale 1ns/1ps
module tb_rally_speed_ctrl;

    localparam int HITS = 3;
    localparam int MAXL = 7;
    localparam int HOLD = 4;
    localparam int WIN  = 9;
    localparam int TOUT = 10;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_RALLY = 2;
    localparam int PH_POINT = 3;
    localparam int PH_OVER  = 4;

    logic clk_in = 1'b0;
    logic rst_n;
    rally_speed_ctrl_if bus();

    rally_speed_ctrl #(
        .HITS_PER_LEVEL(HITS), .MAX_LEVEL(MAXL), .HOLD_STEPS(HOLD),
        .WIN_SCORE(WIN), .SERVE_TIMEOUT(TOUT)
    ) u_dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #12.5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Game-level model: phase, hits this rally, points, steps spent in the current phase.
    int m_ph, m_hits, m_sl, m_sr, m_hold, m_wait, m_winner;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_level();
        int l;
        l = m_hits / HITS;
        return (l > MAXL) ? MAXL : l;
    endfunction

    task automatic m_reset();
        m_ph = PH_IDLE; m_hits = 0; m_sl = 0; m_sr = 0; m_hold = 0; m_wait = 0; m_winner = 0;
    endtask

    task automatic m_enter_serve();
        m_ph = PH_SERVE; m_hits = 0; m_wait = 0;
    endtask

    task automatic m_serve();
        if (m_ph == PH_IDLE) begin
            m_sl = 0; m_sr = 0;
            m_enter_serve();
        end else if (m_ph == PH_SERVE) m_ph = PH_RALLY;
        else if (m_ph == PH_OVER) m_ph = PH_IDLE;
    endtask

    task automatic m_step();
        if (m_ph == PH_SERVE) begin
            m_wait++;
`ifdef SERVE_TIMEOUT_EN
            if (m_wait == TOUT) m_ph = PH_RALLY;
`endif
        end else if (m_ph == PH_POINT) begin
            m_hold++;
            if (m_hold == HOLD) begin
                if (m_sl == WIN || m_sr == WIN) begin
                    m_ph = PH_OVER;
                    m_winner = (m_sr == WIN) ? 1 : 0;
                end else m_enter_serve();
            end
        end
    endtask

    task automatic m_cycle(input bit hit, input bit ml, input bit mr);
        if (m_ph != PH_RALLY) return;
        if (ml) begin
            m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
            m_ph = PH_POINT; m_hold = 0;
        end else if (mr) begin
            m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
            m_ph = PH_POINT; m_hold = 0;
        end else if (hit) m_hits++;
    endtask

    task automatic check_all(input string w);
        chk({w, ":run"},   bus.run,         32'(m_ph == PH_RALLY));
        chk({w, ":point"}, bus.point_flag,  32'(m_ph == PH_POINT));
        chk({w, ":over"},  bus.game_over,   32'(m_ph == PH_OVER));
        chk({w, ":speed"}, bus.speed_level, 32'(m_level()));
        chk({w, ":sl"},    bus.score_l,     32'(m_sl));
        chk({w, ":sr"},    bus.score_r,     32'(m_sr));
        if (m_ph == PH_OVER) chk({w, ":winner"}, bus.winner, 32'(m_winner));
    endtask

    task automatic op_pulse(input bit hit, input bit ml, input bit mr);
        @(negedge clk_in);
        bus.paddle_hit = hit; bus.miss_l = ml; bus.miss_r = mr;
        @(negedge clk_in);
        bus.paddle_hit = 1'b0; bus.miss_l = 1'b0; bus.miss_r = 1'b0;
        m_cycle(hit, ml, mr);
        repeat (2) @(negedge clk_in);
        check_all("pulse");
    endtask

    task automatic op_serve();
        @(negedge clk_in);
        bus.serve_btn = 1'b1;
        repeat (5) @(negedge clk_in);
        m_serve();
        check_all("serve");
        bus.serve_btn = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic op_step();
        @(negedge clk_in);
        #($urandom_range(1, 20));
        bus.div_clk = ~bus.div_clk;
        repeat (6) @(negedge clk_in);
        m_step();
        check_all("step");
    endtask

    task automatic do_reset();
        #($urandom_range(1, 20));
        rst_n = 1'b0;
        #3;
        m_reset();
        check_all("reset");
        chk("reset:winner", bus.winner, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic to_rally();
        for (int k = 0; k < 8 && m_ph != PH_RALLY; k++) begin
            if (m_ph == PH_POINT) op_step();
            else op_serve();
        end
        chk("to_rally:run", bus.run, 1);
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        bus.div_clk = 1'b0; bus.serve_btn = 1'b0;
        bus.paddle_hit = 1'b0; bus.miss_l = 1'b0; bus.miss_r = 1'b0;
        m_reset();
        repeat (3) @(negedge clk_in);
        check_all("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // Serve sequence and speed ramp
        op_serve();
        chk("dir:serve1_run", bus.run, 0);
        op_serve();
        chk("dir:serve2_run", bus.run, 1);
        repeat (3) op_pulse(1, 0, 0);
        chk("dir:speed3", bus.speed_level, 1);
        repeat (18) op_pulse(1, 0, 0);
        chk("dir:speed21", bus.speed_level, 7);
        repeat (9) op_pulse(1, 0, 0);
        chk("dir:speed30", bus.speed_level, 7);

        // Reset mid-rally
        do_reset();
        chk("dir:rst_run", bus.run, 0);

        // Miss with simultaneous hit, then POINT duration
        op_serve(); op_serve();
        repeat (3) op_pulse(1, 0, 0);
        op_pulse(1, 0, 1);
        chk("dir:hitmiss_sl", bus.score_l, 1);
        chk("dir:hitmiss_speed", bus.speed_level, 1);
        repeat (HOLD - 1) op_step();
        chk("dir:point_held", bus.point_flag, 1);
        op_step();
        chk("dir:point_done", bus.point_flag, 0);
        chk("dir:serve_speed0", bus.speed_level, 0);

        // Double miss
        to_rally();
        op_pulse(0, 1, 1);
        chk("dir:dbl_sr", bus.score_r, 1);
        chk("dir:dbl_sl", bus.score_l, 1);

        // Game end
        do_reset();
        for (int g = 0; g < 12 && m_ph != PH_OVER; g++) begin
            to_rally();
            op_pulse(0, 1, 0);
            repeat (HOLD) op_step();
        end
        chk("dir:go_over", bus.game_over, 1);
        chk("dir:go_winner", bus.winner, 1);
        chk("dir:go_sr", bus.score_r, 9);
        op_pulse(1, 0, 0);
        op_serve();
        chk("dir:idle_over", bus.game_over, 0);
        chk("dir:idle_sr", bus.score_r, 9);
        op_serve();
        chk("dir:new_sr", bus.score_r, 0);

        // Auto-serve behaviour
        repeat (TOUT + 2) op_step();
`ifdef SERVE_TIMEOUT_EN
        chk("dir:autoserve_run", bus.run, 1);
`else
        repeat (100 - TOUT - 2) op_step();
        chk("dir:noauto_run", bus.run, 0);
`endif

        // Random events
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 20) op_serve();
            else if (r < 50) op_step();
            else if (r < 72) op_pulse(1, 0, 0);
            else if (r < 80) op_pulse(0, 1, 0);
            else if (r < 88) op_pulse(0, 0, 1);
            else if (r < 92) op_pulse(0, 1, 1);
            else if (r < 96) op_pulse(1, 0, 1);
            else if (r < 99) op_pulse(1, 1, 0);
            else do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rally_speed_ctrl.md
# rally_speed_ctrl

Game-sequencing controller that drives the ball clock divider's 3-bit speed input and gates ball motion. It counts paddle hits to raise the speed level, detects misses, keeps score, and steps through serve, rally, point-hold and game-over phases. It sits between the paddle/ball collision logic and the clock divider.

## Interface
- HITS_PER_LEVEL, 3: paddle hits per speed-level increment; legal range 1..15.
- MAX_LEVEL, 7: saturation value of speed_level; legal range 0..7.
- HOLD_STEPS, 4: game steps spent in POINT before the next serve; legal range 1..255.
- WIN_SCORE, 9: score that ends the game; legal range 1..15.
- SERVE_TIMEOUT, 10: steps before auto-serve; legal range 1..255; used only with SERVE_TIMEOUT_EN.
- clk_in, input, 1: system clock (40 MHz).
- rst_n, input, 1: asynchronous, active-low reset.
- div_clk, input, 1: divider output, treated as asynchronous. Every edge of div_clk is one game step.
- serve_btn, input, 1: level input; a rising edge requests a serve or a new game.
- paddle_hit, input, 1: single-cycle pulse when the ball hits either paddle.
- miss_l, input, 1: single-cycle pulse when the ball passes the left paddle. Scores a point for right.
- miss_r, input, 1: single-cycle pulse when the ball passes the right paddle. Scores a point for left.
- speed_level, output, 3: speed index sent to the divider.
- run, output, 1: ball-motion enable.
- point_flag, output, 1: high while in POINT.
- score_l, output, 4: left player's score.
- score_r, output, 4: right player's score.
- game_over, output, 1: high while in GAME_OVER.
- winner, output, 1: 0 means left won, 1 means right won. Valid only while game_over is high.

## Operation
- Step detection: div_clk goes through a 2-flop synchronizer, then an XOR edge detect against a third flop. The result is a single-cycle pulse, step, on every div_clk edge.
- Serve detection: serve_btn goes through a 2-flop synchronizer and a rising-edge detect, giving serve_p.
- States:
  - IDLE: wait for a serve.
  - SERVE: ball parked, run low.
  - RALLY: ball moving, run high.
  - POINT: hold after a miss.
  - GAME_OVER: game finished.
- Transitions:
  - IDLE to SERVE on serve_p. Scores clear to 0 on this transition.
  - SERVE to RALLY on serve_p.
  - RALLY to POINT on miss_l or miss_r.
  - POINT to SERVE when the hold counter reaches HOLD_STEPS steps.
  - POINT to GAME_OVER instead, if either score equals WIN_SCORE.
  - GAME_OVER to IDLE on serve_p.
- Hit counting in RALLY: each paddle_hit increments hit_cnt. When hit_cnt would reach HITS_PER_LEVEL:
  - hit_cnt clears;
  - speed_level increments, saturating at MAX_LEVEL.
- Entering SERVE from any state clears speed_level and hit_cnt to 0. Each rally therefore starts slow.
- Scoring happens on the miss cycle, on entry to POINT:
  - miss_l increments score_r;
  - miss_r increments score_l.
  - Scores saturate at WIN_SCORE.
- Simultaneous events in RALLY:
  - A miss takes priority over paddle_hit in the same cycle; the hit is ignored.
  - If miss_l and miss_r arrive together, only miss_l counts (score_r increments).
- Events outside RALLY: paddle_hit, miss_l and miss_r are ignored in every other state. serve_p is ignored in RALLY and POINT.
- Winner: winner is latched on entry to GAME_OVER. It is 1 if score_r equals WIN_SCORE, otherwise 0.

## Timing
- Reset values: state IDLE, speed_level 0, run 0, point_flag 0, score_l 0, score_r 0, game_over 0, winner 0. All counters and synchronizer flops are 0.
- Reset is asynchronous and applies immediately mid-operation. Release is synchronous to clk_in.
- Latency from div_clk edge to step pulse: 2 to 3 clk_in cycles. Latency from serve_btn rise to serve_p: 2 to 3 cycles.
- All outputs are registered and change one cycle after the causing event:
  - run rises the cycle after serve_p is seen in SERVE;
  - run falls the cycle after a miss pulse.
- speed_level updates one cycle after the qualifying paddle_hit. It never wraps.
- The POINT hold counter is 8 bits and clears on POINT entry. The exit condition is hold_cnt equal to HOLD_STEPS-1 together with step, so POINT lasts exactly HOLD_STEPS steps.
- Counter widths: hit_cnt 4 bits, scores 4 bits, hold and timeout counters 8 bits. There is no overflow, given the parameter ranges.

## Configuration
- SERVE_TIMEOUT_EN defined:
  - SERVE keeps an 8-bit step counter, cleared on SERVE entry.
  - After SERVE_TIMEOUT steps without serve_p, the block serves automatically (SERVE to RALLY, identical to a serve_p).
  - If serve_p and the timeout occur in the same cycle, the result is a single transition.
- SERVE_TIMEOUT_EN undefined: no timeout counter; SERVE waits indefinitely for serve_p. The SERVE_TIMEOUT parameter is unused.

## Test plan
- Reset and serve: assert rst_n=0 mid-rally, then release.
  - Expect all outputs at their reset values.
  - A serve_btn rise gives state SERVE with run still 0; a second rise gives run=1.
- Speed ramp (defaults): 3 paddle_hit pulses give speed_level 1; 21 hits give 7; 30 hits keep it at 7. Next serve returns speed_level to 0.
- Miss with hit in the same cycle (paddle_hit=1 together with miss_r=1), and double miss (miss_l=1 together with miss_r=1):
  - first case: score_l +1, speed_level unchanged, point_flag=1 for exactly 4 steps, then SERVE;
  - second case: only score_r increments.
- Game end: 9 consecutive miss_l pulses give score_r=9, game_over=1, winner=1. A paddle_hit in GAME_OVER has no effect; serve_btn rise returns to IDLE with scores unchanged, and the next serve clears them to 0.
- Step detection: toggle div_clk asynchronously. Each edge yields exactly one step pulse, checked by the POINT duration counting HOLD_STEPS edges.
- SERVE_TIMEOUT_EN: with the macro, no serve_btn for 10 steps makes run rise automatically. Without the macro, run stays 0 after 100 steps.
